if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current pc and chip-enable and reads one 32-bit instruction as four byte reads from a byte-wide synchronous RAM port. The RAM returns data one cycle after the address.
- Assembles the bytes little-endian and hands {inst, inst_pc} to the IF/ID boundary with a valid/ready handshake.
- Drives stall_req back to the PC register so pc advances exactly once per completed fetch.

Parameters:
- ADDR_WIDTH, 32, width of pc, mem_addr and inst_pc.
- INST_WIDTH, 32, instruction width. Fixed at 4 bytes in this revision.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset (`RstEnable = 1).
- ce  input  1  fetch enable from the PC register; 0 means no fetch is started.
- pc  input  ADDR_WIDTH  address of the next instruction; sampled only in IDLE.
- flush  input  1  jump taken; aborts the fetch in progress and drops the held output.
- mem_busy  input  1  RAM port owned by the MEM stage this cycle; no address is issued.
- mem_din  input  8  RAM read data; valid the cycle after the address was issued.
- mem_rd  output  1  read strobe for this cycle (combinational).
- mem_addr  output  ADDR_WIDTH  byte address for this cycle (combinational; 0 when mem_rd=0).
- stall_req  output  1  PC register holds pc while 1 (combinational).
- inst_valid  output  1  inst/inst_pc hold a fetched instruction.
- inst  output  INST_WIDTH  assembled instruction.
- inst_pc  output  ADDR_WIDTH  address the instruction was fetched from.
- id_ready  input  1  decode accepts inst this cycle.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pend=0, fetch_pc=0, asm=0, inst_valid=0, inst=0, inst_pc=0. Reset mid-fetch discards all partial bytes; any late mem_din is ignored.
- States: IDLE, RD1, RD2, RD3, WB. Internal registers: fetch_pc, asm[23:0], pend (a byte is due on mem_din this cycle).
- IDLE, start condition: ce=1, flush=0, mem_busy=0, and (inst_valid=0 or id_ready=1).
  - When the start condition holds: mem_rd=1, mem_addr=pc, fetch_pc<=pc, pend<=1, go to RD1.
  - Otherwise stay in IDLE with mem_rd=0.
- RDk (k=1..3):
  - If pend=1, capture mem_din into byte k-1 of asm.
  - If mem_busy=0: mem_rd=1, mem_addr=fetch_pc+k, pend<=1, advance (RD3 goes to WB).
  - If mem_busy=1: mem_rd=0, pend<=0, stay in RDk.
- WB:
  - Byte 3 is on mem_din. inst<={mem_din, asm[23:0]}, inst_pc<=fetch_pc, inst_valid<=1, go to IDLE.
  - mem_busy is ignored in WB.
- Minimum latency: 5 cycles from IDLE start to the WB edge. inst_valid is high in the following cycle. Peak throughput is 1 instruction per 5 cycles.
- Output handshake:
  - inst_valid/inst/inst_pc hold while inst_valid=1 and id_ready=0.
  - inst_valid=1 and id_ready=1 at posedge clears inst_valid, unless WB sets it on the same edge; set wins.
  - The IDLE start rule guarantees the slot is free when WB is reached.
- stall_req = (state != WB). pc therefore advances only on the WB edge. A PC-register jump overrides stall_req.
- flush=1 at posedge in any state: go to IDLE, pend<=0, inst_valid<=0. No address is issued that cycle. flush has priority over WB completion and over id_ready.
- Address arithmetic: fetch_pc+k is modulo 2^ADDR_WIDTH, so it wraps at the top of the address space. Misaligned pc is fetched as-is, with no trap.

Decomposition:
- Shared defines: `RstEnable, `ChipEnable/`ChipDisable, `InstAddrBus, `InstBus, `True/`False.
- Local localparams for state encoding (3 bits).
- One natural sub-module: if_byte_asm (byte-lane capture into asm plus final concatenation). Everything else stays in if_fetch.

Test Plan:
- RAM[0..3]=13 05 10 00, ce=1, id_ready=1 from reset release.
  - mem_addr sequence is 0,1,2,3.
  - inst_valid=1, inst=0x00100513, inst_pc=0 in the 6th cycle.
  - stall_req=0 only in the WB cycle.
- Back-to-back fetch of pc=0 then pc=4 (RAM[4..7]=93 05 20 00).
  - Second instruction is 0x00200593 with inst_pc=4, exactly 5 cycles after the first.
- id_ready=0 for 8 cycles after the first instruction.
  - inst/inst_pc stay stable and no second mem_rd occurs.
  - After id_ready=1, the second fetch starts the next cycle.
- mem_busy=1 for 2 cycles while in RD2.
  - Byte 1 is still captured; no address is issued during the busy cycles.
  - Address 2 is issued afterwards; inst is correct, with latency 7.
- flush=1 in RD3.
  - Next cycle is IDLE with inst_valid=0 and no WB.
  - New pc=0x40 is fetched with correct inst and inst_pc=0x40.
- rst=1 in RD2.
  - All outputs are 0 on the next cycle and mem_rd=0.
  - After rst=0, the fetch restarts from the current pc.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Fetches one 32-bit instruction as four byte reads.
package if_fetch_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_RD3  = 3'd3,
    ST_WB   = 3'd4
  } fetch_state_e;

  // Byte lane of asm that receives the read data arriving in a given RD state.
  function automatic logic [1:0] lane_of(input fetch_state_e s);
    case (s)
      ST_RD2:  lane_of = 2'd1;
      ST_RD3:  lane_of = 2'd2;
      default: lane_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_byte_asm.sv
// Little-endian byte assembler: collects bytes 0..2 of an instruction and
// forms the full word with byte 3 taken straight from the RAM data bus.
module if_byte_asm
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  logic [23:0] asm_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      asm_q <= '0;
    end else if (cap) begin
      case (lane)
        2'd0:    asm_q[7:0]   <= din;
        2'd1:    asm_q[15:8]  <= din;
        2'd2:    asm_q[23:16] <= din;
        default: asm_q        <= asm_q;
      endcase
    end
  end

  assign word = {din, asm_q};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: four byte reads from a synchronous RAM port,
// little-endian assembly, valid/ready handoff to decode, stall back to PC.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = INST_ADDR_W,
  parameter int INST_WIDTH = INST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  input  logic                  mem_busy,
  input  logic [7:0]            mem_din,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  stall_req,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  id_ready
);

  fetch_state_e          state, state_nxt;
  logic                  pend, pend_nxt;
  logic                  start;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  cap;
  logic [31:0]           asm_word;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= ST_IDLE;
      pend     <= 1'b0;
      fetch_pc <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (start) fetch_pc <= pc;
    end
  end

  // A new fetch may only begin once the output slot is free or being drained.
  always_comb begin
    state_nxt = state;
    pend_nxt  = 1'b0;
    start     = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      ST_IDLE: begin
        if (ce == CHIP_ENABLE && !mem_busy && (!inst_valid || id_ready)) begin
          start     = 1'b1;
          mem_rd    = 1'b1;
          mem_addr  = pc;
          pend_nxt  = 1'b1;
          state_nxt = ST_RD1;
        end
      end
      ST_RD1: begin
        if (!mem_busy) begin
          mem_rd    = 1'b1;
          mem_addr  = fetch_pc + ADDR_WIDTH'(1);
          pend_nxt  = 1'b1;
          state_nxt = ST_RD2;
        end
      end
      ST_RD2: begin
        if (!mem_busy) begin
          mem_rd    = 1'b1;
          mem_addr  = fetch_pc + ADDR_WIDTH'(2);
          pend_nxt  = 1'b1;
          state_nxt = ST_RD3;
        end
      end
      ST_RD3: begin
        if (!mem_busy) begin
          mem_rd    = 1'b1;
          mem_addr  = fetch_pc + ADDR_WIDTH'(3);
          pend_nxt  = 1'b1;
          state_nxt = ST_WB;
        end
      end
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Flush or reset: nothing goes out on the RAM port this cycle.
    if (flush || rst == RST_ENABLE) begin
      start     = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      pend_nxt  = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  assign cap       = pend && (state inside {ST_RD1, ST_RD2, ST_RD3});
  assign stall_req = (state != ST_WB);

  if_byte_asm u_asm (
    .clk  (clk),
    .rst  (rst),
    .cap  (cap),
    .lane (lane_of(state)),
    .din  (mem_din),
    .word (asm_word)
  );

  // Output slot: flush beats WB completion, which beats the decode handshake.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (state == ST_WB) begin
      inst_valid <= 1'b1;
      inst       <= INST_WIDTH'(asm_word);
      inst_pc    <= fetch_pc;
    end else if (inst_valid && id_ready) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte RAM model and a simple PC register.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, ce, flush, mem_busy, id_ready;
  logic [31:0] pc;
  logic [7:0]  mem_din;
  logic        mem_rd, stall_req, inst_valid;
  logic [31:0] mem_addr, inst, inst_pc;

  logic        pc_rst, jmp;
  logic [31:0] jmp_pc;
  logic [7:0]  ram [0:255];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc         (pc),
    .flush      (flush),
    .mem_busy   (mem_busy),
    .mem_din    (mem_din),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .stall_req  (stall_req),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .id_ready   (id_ready)
  );

  // Synchronous RAM: data one cycle after the address; junk when not read.
  always @(posedge clk) mem_din <= mem_rd ? ram[mem_addr[7:0]] : 8'hEE;

  // PC register: advances by 4 only when not stalled; a jump overrides.
  always @(posedge clk) begin
    if (pc_rst)          pc <= 32'h0;
    else if (jmp)        pc <= jmp_pc;
    else if (!stall_req) pc <= pc + 32'd4;
  end

  task automatic test_reset();
    rst = 1'b1; pc_rst = 1'b1; ce = 1'b1; id_ready = 1'b1;
    flush = 1'b0; mem_busy = 1'b0; jmp = 1'b0; jmp_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    vecs++; if (inst !== 32'h0) begin errs++; $display("FAIL rst_inst: got %h want 0", inst); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    vecs++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL rst_stall: got %b want 1", stall_req); end
  endtask

  task automatic test_first_fetch();
    logic        e_rd [6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd4};
    logic        e_st [6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    rst = 1'b0; pc_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      vecs++; if (mem_rd !== e_rd[c]) begin errs++; $display("FAIL first_rd[%0d]: got %b want %b", c, mem_rd, e_rd[c]); end
      vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL first_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
      vecs++; if (stall_req !== e_st[c]) begin errs++; $display("FAIL first_stall[%0d]: got %b want %b", c, stall_req, e_st[c]); end
      vecs++; if (inst_valid !== (c == 5)) begin errs++; $display("FAIL first_valid[%0d]: got %b want %b", c, inst_valid, (c == 5)); end
    end
    vecs++; if (inst !== 32'h00100513) begin errs++; $display("FAIL first_inst: got %h want 00100513", inst); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL first_inst_pc: got %h want 0", inst_pc); end
  endtask

  task automatic test_back_to_back();
    logic        e_rd [4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_addr [4] = '{32'd5, 32'd6, 32'd7, 32'd0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      vecs++; if (mem_rd !== e_rd[c]) begin errs++; $display("FAIL b2b_rd[%0d]: got %b want %b", c, mem_rd, e_rd[c]); end
      vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL b2b_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
      vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 0", c, inst_valid); end
    end
    // Fifth cycle after the first instruction: decode now refuses it.
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid2: got %b want 1", inst_valid); end
    vecs++; if (inst !== 32'h00200593) begin errs++; $display("FAIL b2b_inst: got %h want 00200593", inst); end
    vecs++; if (inst_pc !== 32'h4) begin errs++; $display("FAIL b2b_inst_pc: got %h want 4", inst_pc); end
    vecs++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL b2b_no_rd: got %b want 0", mem_rd); end
  endtask

  task automatic test_hold();
    logic        e_rd [5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr [5] = '{32'd9, 32'd10, 32'd11, 32'd0, 32'd12};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL hold_valid[%0d]: got %b want 1", i, inst_valid); end
      vecs++; if (inst !== 32'h00200593) begin errs++; $display("FAIL hold_inst[%0d]: got %h want 00200593", i, inst); end
      vecs++; if (inst_pc !== 32'h4) begin errs++; $display("FAIL hold_inst_pc[%0d]: got %h want 4", i, inst_pc); end
      vecs++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL hold_no_rd[%0d]: got %b want 0", i, mem_rd); end
    end
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    vecs++; if (mem_rd !== 1'b1) begin errs++; $display("FAIL hold_start_rd: got %b want 1", mem_rd); end
    vecs++; if (mem_addr !== 32'd8) begin errs++; $display("FAIL hold_start_addr: got %h want 8", mem_addr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      vecs++; if (mem_rd !== e_rd[c]) begin errs++; $display("FAIL hold_rd[%0d]: got %b want %b", c, mem_rd, e_rd[c]); end
      vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL hold_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
      vecs++; if (inst_valid !== (c == 4)) begin errs++; $display("FAIL hold_valid2[%0d]: got %b want %b", c, inst_valid, (c == 4)); end
    end
    vecs++; if (inst !== 32'h00300613) begin errs++; $display("FAIL hold_inst2: got %h want 00300613", inst); end
    vecs++; if (inst_pc !== 32'h8) begin errs++; $display("FAIL hold_inst_pc2: got %h want 8", inst_pc); end
  endtask

  task automatic test_busy();
    logic        busy [7]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        e_rd [7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr [7] = '{32'd13, 32'd0, 32'd0, 32'd14, 32'd15, 32'd0, 32'd16};
    logic        e_st [7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      mem_busy = busy[c];
      #1;
      vecs++; if (mem_rd !== e_rd[c]) begin errs++; $display("FAIL busy_rd[%0d]: got %b want %b", c, mem_rd, e_rd[c]); end
      vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL busy_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
      vecs++; if (stall_req !== e_st[c]) begin errs++; $display("FAIL busy_stall[%0d]: got %b want %b", c, stall_req, e_st[c]); end
      vecs++; if (inst_valid !== (c == 6)) begin errs++; $display("FAIL busy_valid[%0d]: got %b want %b", c, inst_valid, (c == 6)); end
    end
    vecs++; if (inst !== 32'h00b506b3) begin errs++; $display("FAIL busy_inst: got %h want 00b506b3", inst); end
    vecs++; if (inst_pc !== 32'hc) begin errs++; $display("FAIL busy_inst_pc: got %h want c", inst_pc); end
  endtask

  task automatic test_flush();
    logic [31:0] e_addr [4] = '{32'h41, 32'h42, 32'h43, 32'h0};
    // Fetch of pc=16 is under way; let it reach RD3.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      vecs++; if (mem_addr !== 32'd17 + 32'(c)) begin errs++; $display("FAIL fl_pre_addr[%0d]: got %h want %h", c, mem_addr, 32'd17 + 32'(c)); end
    end
    @(negedge clk);
    flush = 1'b1; jmp = 1'b1; jmp_pc = 32'h40;
    #1;
    vecs++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL fl_rd3_rd: got %b want 0", mem_rd); end
    @(negedge clk);
    flush = 1'b0; jmp = 1'b0;
    #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL fl_valid: got %b want 0", inst_valid); end
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL fl_no_wb: got %b want 1", stall_req); end
    vecs++; if (mem_addr !== 32'h40 || mem_rd !== 1'b1) begin errs++; $display("FAIL fl_restart: got rd=%b addr=%h want rd=1 addr=40", mem_rd, mem_addr); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL fl_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
    end
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL fl_valid2: got %b want 1", inst_valid); end
    vecs++; if (inst !== 32'h00001237) begin errs++; $display("FAIL fl_inst: got %h want 00001237", inst); end
    vecs++; if (inst_pc !== 32'h40) begin errs++; $display("FAIL fl_inst_pc: got %h want 40", inst_pc); end
    // Flush while the instruction is held drops it.
    @(negedge clk);
    flush = 1'b1;
    #1;
    vecs++; if (inst_valid !== 1'b1 || mem_rd !== 1'b0) begin errs++; $display("FAIL fl_held: got valid=%b rd=%b want valid=1 rd=0", inst_valid, mem_rd); end
    @(negedge clk);
    flush = 1'b0; id_ready = 1'b1;
    #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL fl_drop: got %b want 0", inst_valid); end
    vecs++; if (mem_rd !== 1'b1 || mem_addr !== 32'h44) begin errs++; $display("FAIL fl_next: got rd=%b addr=%h want rd=1 addr=44", mem_rd, mem_addr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e_addr [5] = '{32'h45, 32'h46, 32'h47, 32'h0, 32'h48};
    @(negedge clk); #1;
    vecs++; if (mem_addr !== 32'h45) begin errs++; $display("FAIL rm_addr1: got %h want 45", mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL rm_rd_in_rst: got %b want 0", mem_rd); end
    @(negedge clk); #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rm_valid: got %b want 0", inst_valid); end
    vecs++; if (inst !== 32'h0) begin errs++; $display("FAIL rm_inst: got %h want 0", inst); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL rm_inst_pc: got %h want 0", inst_pc); end
    vecs++; if (mem_rd !== 1'b0 || mem_addr !== 32'h0) begin errs++; $display("FAIL rm_port: got rd=%b addr=%h want rd=0 addr=0", mem_rd, mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++; if (mem_rd !== 1'b1 || mem_addr !== 32'h44) begin errs++; $display("FAIL rm_restart: got rd=%b addr=%h want rd=1 addr=44", mem_rd, mem_addr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (c < 4) begin
        vecs++; if (mem_addr !== e_addr[c]) begin errs++; $display("FAIL rm_addr[%0d]: got %h want %h", c, mem_addr, e_addr[c]); end
      end
      vecs++; if (inst_valid !== (c == 4)) begin errs++; $display("FAIL rm_valid2[%0d]: got %b want %b", c, inst_valid, (c == 4)); end
    end
    vecs++; if (inst !== 32'h00400713) begin errs++; $display("FAIL rm_inst2: got %h want 00400713", inst); end
    vecs++; if (inst_pc !== 32'h44) begin errs++; $display("FAIL rm_inst_pc2: got %h want 44", inst_pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0]    = 8'h13; ram[1]    = 8'h05; ram[2]    = 8'h10; ram[3]    = 8'h00;
    ram[4]    = 8'h93; ram[5]    = 8'h05; ram[6]    = 8'h20; ram[7]    = 8'h00;
    ram[8]    = 8'h13; ram[9]    = 8'h06; ram[10]   = 8'h30; ram[11]   = 8'h00;
    ram[12]   = 8'hb3; ram[13]   = 8'h06; ram[14]   = 8'hb5; ram[15]   = 8'h00;
    ram[8'h40] = 8'h37; ram[8'h41] = 8'h12; ram[8'h42] = 8'h00; ram[8'h43] = 8'h00;
    ram[8'h44] = 8'h13; ram[8'h45] = 8'h07; ram[8'h46] = 8'h40; ram[8'h47] = 8'h00;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_hold();
    test_busy();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
